// File: rtl/lsu_ctrl_if.sv
// Core and data-memory signals of the load/store controller.
// The controller connects through the slave modport; the core/memory side uses master.
interface lsu_ctrl_if;
  logic        Req;
  logic        WrEn;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic        AddrErr;
  logic [31:0] LoadData;
  logic [29:0] MemAd;
  logic [31:0] MemWrData;
  logic        MemWr;
  logic [31:0] MemRdData;

  modport slave (
    input  Req, WrEn, Size, SignExt, Addr, StoreData, MemRdData,
    output Busy, Done, AddrErr, LoadData, MemAd, MemWrData, MemWr
  );

  modport master (
    output Req, WrEn, Size, SignExt, Addr, StoreData, MemRdData,
    input  Busy, Done, AddrErr, LoadData, MemAd, MemWrData, MemWr
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: aligned word reads, sub-word extract/extend,
// read-modify-write for sub-word stores, one-cycle Done pulse.
module lsu_ctrl #(
  parameter bit BIG_ENDIAN        = 1'b0,
  parameter bit WORD_STORE_BYPASS = 1'b1
) (
  input  logic     Clk,
  input  logic     Reset,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [1:0]  addr_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        sext_q;
  logic [31:0] sdata_q;

  logic        misaligned;
  logic        bypass;
  logic [4:0]  bsh, hsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val, mask, ins, merge_val;

  assign bus.Busy = (state != IDLE);

  assign misaligned = (bus.Size == 2'b11) ||
                      (bus.Size == 2'b01 && bus.Addr[0]) ||
                      (bus.Size == 2'b10 && bus.Addr[1:0] != 2'b00);
  assign bypass     = WORD_STORE_BYPASS && bus.WrEn && bus.Size == 2'b10;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.Req) begin
              if (misaligned)  state_next = ERR;
              else if (bypass) state_next = WR;
              else             state_next = RD;
            end
      RD:   state_next = CAP;
      CAP:  state_next = wr_q ? WR : DONE;
      WR:   state_next = DONE;
      DONE: state_next = IDLE;
      ERR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Big-endian mirrors the lanes: byte k lives at 3-k, half 0 at the top.
  always_comb begin
    bsh    = {(BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0]), 3'b000};
    hsh    = {(BIG_ENDIAN ? ~addr_q[1] : addr_q[1]), 4'b0000};
    byte_v = 8'(bus.MemRdData >> bsh);
    half_v = 16'(bus.MemRdData >> hsh);
    load_val = bus.MemRdData;
    mask     = '1;
    ins      = sdata_q;
    case (size_q)
      2'b00: begin
        load_val = sext_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        mask     = 32'h0000_00FF << bsh;
        ins      = {24'h0, sdata_q[7:0]} << bsh;
      end
      2'b01: begin
        load_val = sext_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        mask     = 32'h0000_FFFF << hsh;
        ins      = {16'h0, sdata_q[15:0]} << hsh;
      end
      default: ;
    endcase
    merge_val = (bus.MemRdData & ~mask) | (ins & mask);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.Done      <= 1'b0;
      bus.AddrErr   <= 1'b0;
      bus.MemWr     <= 1'b0;
      bus.LoadData  <= '0;
      bus.MemAd     <= '0;
      bus.MemWrData <= '0;
      addr_q        <= '0;
      size_q        <= '0;
      wr_q          <= 1'b0;
      sext_q        <= 1'b0;
      sdata_q       <= '0;
    end else begin
      bus.Done    <= (state_next == DONE) || (state_next == ERR);
      bus.AddrErr <= (state_next == ERR);
      bus.MemWr   <= (state_next == WR);
      if (state == IDLE && bus.Req) begin
        addr_q    <= bus.Addr[1:0];
        size_q    <= bus.Size;
        wr_q      <= bus.WrEn;
        sext_q    <= bus.SignExt;
        sdata_q   <= bus.StoreData;
        bus.MemAd <= bus.Addr[31:2];
        if (bypass && !misaligned) bus.MemWrData <= bus.StoreData;
      end
      if (state == CAP) begin
        if (wr_q) bus.MemWrData <= merge_val;
        else      bus.LoadData  <= load_val;
      end
    end
  end

endmodule
